// File: rtl/wb_exc_commit.sv
// ---------------------------------------------------------------------------
// wb_exc_commit
//   WB-stage commit/exception controller. Holds the instruction handed over
//   by MEM, resolves interrupt/exception priority, issues CSR writes and the
//   wb_ex / ertn_flush strobes, then redirects IF to the exception entry or
//   the ERA value through a valid/ready handshake while flushing IF..MEM.
//   Optional feature macro: WB_EXC_COUNT_EN (committed exception counter).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_exc_commit #(
  parameter int CSR_NUM_W = 14,
  parameter int XLEN      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ms_to_ws_valid,
  output logic                          ws_allowin,
  input  logic [XLEN-1:0]               ms_pc,
  input  logic [4:0]                    ms_exc,
  input  logic [XLEN-1:0]               ms_vaddr,
  input  logic                          ms_ertn,
  input  logic [CSR_NUM_W+2*XLEN:0]     ms_csr_bus,
  input  logic                          has_int,
  input  logic [XLEN-1:0]               ex_entry,
  input  logic [XLEN-1:0]               ertn_pc,
  output logic                          csr_we,
  output logic [CSR_NUM_W-1:0]          csr_num,
  output logic [XLEN-1:0]               csr_wmask,
  output logic [XLEN-1:0]               csr_wvalue,
  output logic                          wb_ex,
  output logic                          ertn_flush,
  output logic [5:0]                    wb_ecode,
  output logic [8:0]                    wb_esubcode,
  output logic [XLEN-1:0]               wb_pc,
  output logic [XLEN-1:0]               wb_vaddr,
  output logic                          ws_flush,
  output logic                          redirect_valid,
  input  logic                          redirect_ready,
  output logic [XLEN-1:0]               redirect_pc,
  output logic [31:0]                   exc_count
);

  localparam int BUS_W = 1 + CSR_NUM_W + 2 * XLEN;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;

  logic              ws_valid;
  logic [XLEN-1:0]   ws_pc;
  logic [4:0]        ws_exc;
  logic [XLEN-1:0]   ws_vaddr;
  logic              ws_ertn;
  logic [BUS_W-1:0]  ws_csr_bus;

  logic              commit;
  logic              has_exc;
  logic              commit_flush;
  logic              load;

  // Only a valid instruction in IDLE commits; an interrupt is taken on it.
  assign commit       = ws_valid & (state == S_IDLE);
  assign has_exc      = has_int | (|ws_exc);
  assign wb_ex        = commit & has_exc;
  assign ertn_flush   = commit & ~has_exc & ws_ertn;
  assign commit_flush = wb_ex | ertn_flush;

  assign ws_allowin   = ~ws_valid | (state == S_IDLE);
  assign load         = ms_to_ws_valid & ws_allowin & (state == S_IDLE) & ~commit_flush;

  // CSR write passes straight through; suppressed by exception or ertn.
  assign csr_we       = commit & ~has_exc & ~ws_ertn & ws_csr_bus[BUS_W-1];
  assign csr_num      = ws_csr_bus[BUS_W-2 -: CSR_NUM_W];
  assign csr_wmask    = ws_csr_bus[2*XLEN-1 -: XLEN];
  assign csr_wvalue   = ws_csr_bus[XLEN-1:0];

  assign wb_pc        = ws_pc;
  assign wb_esubcode  = 9'd0;
  assign ws_flush     = commit_flush | (state == S_REDIR);
  assign redirect_valid = (state == S_REDIR);

  // WB valid bit: refilled from MEM only when idle and not flushing.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else begin
      ws_valid <= load;
    end
  end

  // WB payload register, captured alongside the valid bit.
  always_ff @(posedge clk) begin
    if (load) begin
      ws_pc      <= ms_pc;
      ws_exc     <= ms_exc;
      ws_vaddr   <= ms_vaddr;
      ws_ertn    <= ms_ertn;
      ws_csr_bus <= ms_csr_bus;
    end
  end

  // Exception priority: INT > ADEF > INE > SYS > BRK > ALE.
  always_comb begin
    wb_ecode = 6'h00;
    wb_vaddr = '0;
    if (has_int) begin
      wb_ecode = 6'h00;
    end else if (ws_exc[4]) begin
      wb_ecode = 6'h08;
      wb_vaddr = ws_pc;
    end else if (ws_exc[3]) begin
      wb_ecode = 6'h0D;
    end else if (ws_exc[2]) begin
      wb_ecode = 6'h0B;
    end else if (ws_exc[1]) begin
      wb_ecode = 6'h0C;
    end else if (ws_exc[0]) begin
      wb_ecode = 6'h09;
      wb_vaddr = ws_vaddr;
    end
  end

  // Redirect state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Enter REDIR on a flushing commit, leave when IF takes the redirect.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (commit_flush)   next_state = S_REDIR;
      S_REDIR: if (redirect_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Redirect target latched at commit and held for the whole handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc <= '0;
    end else if (commit_flush) begin
      redirect_pc <= wb_ex ? ex_entry : ertn_pc;
    end
  end

`ifdef WB_EXC_COUNT_EN
  logic [31:0] exc_cnt_q;

  // Count committed exceptions; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt_q <= 32'd0;
    end else if (wb_ex) begin
      exc_cnt_q <= exc_cnt_q + 32'd1;
    end
  end

  assign exc_count = exc_cnt_q;
`else
  assign exc_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_exc_commit.sv
// ---------------------------------------------------------------------------
// tb_wb_exc_commit
//   Directed bench for wb_exc_commit: exception priority, interrupts, ertn,
//   CSR pass-through, redirect handshake, reset mid-redirect, counter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_exc_commit;

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_exc;
  logic [31:0] ms_vaddr;
  logic        ms_ertn;
  logic [78:0] ms_csr_bus;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ws_flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] exc_count;

  int total = 0;
  int bad   = 0;

  wb_exc_commit dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_exc(ms_exc), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
    .ms_csr_bus(ms_csr_bus), .has_int(has_int), .ex_entry(ex_entry), .ertn_pc(ertn_pc),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ws_flush(ws_flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for a single cycle; on return it sits in WB.
  task automatic issue(input logic [31:0] pc, input logic [4:0] exc,
                       input logic [31:0] vaddr, input logic ertn, input logic [78:0] bus);
    ms_to_ws_valid = 1'b1;
    ms_pc = pc; ms_exc = exc; ms_vaddr = vaddr; ms_ertn = ertn; ms_csr_bus = bus;
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
    ms_exc = 5'd0; ms_ertn = 1'b0; ms_csr_bus = '0;
  endtask

  // From a commit cycle: go through REDIR with ready high and return to IDLE.
  task automatic drain;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
    total++; if ({wb_ex, ertn_flush, csr_we, ws_flush} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {wb_ex, ertn_flush, csr_we, ws_flush}); end
    total++; if (redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    total++; if (exc_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", exc_count); end
    total++; if (ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", ws_allowin); end
    reset = 1'b0;
  endtask

  task automatic test_sys;
    ex_entry = 32'h1c008000;
    redirect_ready = 1'b0;
    issue(32'h1c000100, 5'b00100, 32'h0, 1'b0, '0);
    total++; if (wb_ex !== 1'b1) begin bad++; $display("FAIL sys_wbex got=%b exp=1", wb_ex); end
    total++; if (wb_ecode !== 6'h0B) begin bad++; $display("FAIL sys_ecode got=%h exp=0b", wb_ecode); end
    total++; if (wb_pc !== 32'h1c000100) begin bad++; $display("FAIL sys_pc got=%h exp=1c000100", wb_pc); end
    total++; if (ws_flush !== 1'b1) begin bad++; $display("FAIL sys_flush got=%b exp=1", ws_flush); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ex_entry = 32'h0badf00d;
      total++; if (redirect_valid !== 1'b1 || wb_ex !== 1'b0 || ws_flush !== 1'b1) begin
        bad++; $display("FAIL sys_redir%0d rv=%b ex=%b fl=%b exp=1 0 1", i, redirect_valid, wb_ex, ws_flush); end
      total++; if (redirect_pc !== 32'h1c008000) begin bad++; $display("FAIL sys_rpc%0d got=%h exp=1c008000", i, redirect_pc); end
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    total++; if (redirect_valid !== 1'b0 || ws_flush !== 1'b0) begin bad++; $display("FAIL sys_done rv=%b fl=%b exp=0 0", redirect_valid, ws_flush); end
  endtask

  task automatic test_priority;
    issue(32'h1c000003, 5'b10001, 32'hdeadbeef, 1'b0, '0);
    total++; if (wb_ecode !== 6'h08 || wb_esubcode !== 9'd0) begin bad++; $display("FAIL adef_ecode got=%h/%h exp=08/0", wb_ecode, wb_esubcode); end
    total++; if (wb_vaddr !== 32'h1c000003) begin bad++; $display("FAIL adef_vaddr got=%h exp=1c000003", wb_vaddr); end
    drain();
    issue(32'h1c000010, 5'b00001, 32'h1c0000a2, 1'b0, '0);
    total++; if (wb_ecode !== 6'h09 || wb_vaddr !== 32'h1c0000a2) begin bad++; $display("FAIL ale got=%h/%h exp=09/1c0000a2", wb_ecode, wb_vaddr); end
    drain();
    issue(32'h1c000014, 5'b01110, 32'h12345678, 1'b0, '0);
    total++; if (wb_ecode !== 6'h0D || wb_vaddr !== 32'd0) begin bad++; $display("FAIL ine got=%h/%h exp=0d/0", wb_ecode, wb_vaddr); end
    drain();
    issue(32'h1c000018, 5'b00011, 32'h12345678, 1'b0, '0);
    total++; if (wb_ecode !== 6'h0C || wb_ex !== 1'b1) begin bad++; $display("FAIL brk got=%h/%b exp=0c/1", wb_ecode, wb_ex); end
    drain();
  endtask

  task automatic test_int;
    has_int = 1'b1;
    #1;
    total++; if (wb_ex !== 1'b0) begin bad++; $display("FAIL int_empty got=%b exp=0", wb_ex); end
    issue(32'h1c000180, 5'b0, 32'h0, 1'b0, {1'b1, 14'h030, 32'hffffffff, 32'h0000005a});
    total++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h00) begin bad++; $display("FAIL int_ex got=%b/%h exp=1/00", wb_ex, wb_ecode); end
    total++; if (csr_we !== 1'b0) begin bad++; $display("FAIL int_csrwe got=%b exp=0", csr_we); end
    total++; if (wb_pc !== 32'h1c000180) begin bad++; $display("FAIL int_pc got=%h exp=1c000180", wb_pc); end
    @(posedge clk); #1;
    total++; if (wb_ex !== 1'b0) begin bad++; $display("FAIL int_redir got=%b exp=0", wb_ex); end
    has_int = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
  endtask

  task automatic test_csr_back_to_back;
    ms_to_ws_valid = 1'b1;
    ms_pc = 32'h1c000200; ms_csr_bus = {1'b1, 14'h030, 32'hffffffff, 32'h0000005a};
    @(posedge clk); #1;
    ms_pc = 32'h1c000204; ms_csr_bus = {1'b0, 14'h001, 32'h0000ffff, 32'h00001234};
    total++; if (csr_we !== 1'b1 || csr_num !== 14'h030 || csr_wmask !== 32'hffffffff || csr_wvalue !== 32'h5a) begin
      bad++; $display("FAIL csr1 we=%b num=%h m=%h v=%h exp=1 030 ffffffff 5a", csr_we, csr_num, csr_wmask, csr_wvalue); end
    total++; if (wb_ex !== 1'b0 || ws_flush !== 1'b0) begin bad++; $display("FAIL csr1_ex ex=%b fl=%b exp=0 0", wb_ex, ws_flush); end
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0; ms_csr_bus = '0;
    total++; if (csr_we !== 1'b0 || csr_num !== 14'h001 || csr_wvalue !== 32'h1234) begin
      bad++; $display("FAIL csr2 we=%b num=%h v=%h exp=0 001 1234", csr_we, csr_num, csr_wvalue); end
    @(posedge clk); #1;
    total++; if (csr_we !== 1'b0) begin bad++; $display("FAIL csr_idle got=%b exp=0", csr_we); end
  endtask

  task automatic test_ertn;
    ertn_pc = 32'h1c000204;
    issue(32'h1c000300, 5'b0, 32'h0, 1'b1, {1'b1, 14'h006, 32'hffffffff, 32'h1});
    total++; if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || csr_we !== 1'b0) begin
      bad++; $display("FAIL ertn got=%b%b%b exp=100", ertn_flush, wb_ex, csr_we); end
    @(posedge clk); #1;
    total++; if (ertn_flush !== 1'b0 || redirect_valid !== 1'b1) begin bad++; $display("FAIL ertn_redir ef=%b rv=%b exp=0 1", ertn_flush, redirect_valid); end
    total++; if (redirect_pc !== 32'h1c000204) begin bad++; $display("FAIL ertn_rpc got=%h exp=1c000204", redirect_pc); end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset_redir;
    issue(32'h1c000400, 5'b00100, 32'h0, 1'b0, '0);
    @(posedge clk); #1;
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rr_pre got=%b exp=1", redirect_valid); end
    ms_to_ws_valid = 1'b1; ms_pc = 32'h1c000404; ms_csr_bus = {1'b1, 14'h030, 32'hffffffff, 32'h77};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ms_to_ws_valid = 1'b0; ms_csr_bus = '0;
    total++; if (redirect_valid !== 1'b0 || ws_allowin !== 1'b1) begin bad++; $display("FAIL rr_post rv=%b al=%b exp=0 1", redirect_valid, ws_allowin); end
    total++; if (csr_we !== 1'b0 || wb_ex !== 1'b0) begin bad++; $display("FAIL rr_drop we=%b ex=%b exp=0 0", csr_we, wb_ex); end
    @(posedge clk); #1;
    total++; if (csr_we !== 1'b0 || ws_flush !== 1'b0) begin bad++; $display("FAIL rr_later we=%b fl=%b exp=0 0", csr_we, ws_flush); end
  endtask

  task automatic test_count;
    logic [31:0] exp_cnt;
`ifdef WB_EXC_COUNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      issue(32'h1c000500 + 32'(i * 4), 5'b00100, 32'h0, 1'b0, '0);
      drain();
    end
    issue(32'h1c000510, 5'b0, 32'h0, 1'b1, '0);
    drain();
    total++; if (exc_count !== exp_cnt) begin bad++; $display("FAIL exc_count got=%0d exp=%0d", exc_count, exp_cnt); end
  endtask

  initial begin
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_pc = '0; ms_exc = '0; ms_vaddr = '0;
    ms_ertn = 1'b0; ms_csr_bus = '0; has_int = 1'b0; ex_entry = '0; ertn_pc = '0;
    redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sys();
    test_priority();
    test_int();
    test_csr_back_to_back();
    test_ertn();
    test_reset_redir();
    test_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
